// File: rtl/pipe_shifter.sv
`default_nettype none
// ============================================================================
// Module   : pipe_shifter
// Purpose  : Pipelined SLL/SRL/SRA/ROR barrel shifter with an elastic valid/ready
//            pipeline. Optional macro PIPE_SHIFTER_SAT_EN makes out-of-range amounts saturate.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_shifter #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] datain,
  input  logic [31:0]      shiftnum,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dataout,
  output logic             shamt_ovf
);

  localparam int SHAMT_W = $clog2(WIDTH);

  localparam logic [1:0] c_sll = 2'b00;
  localparam logic [1:0] c_srl = 2'b01;
  localparam logic [1:0] c_sra = 2'b10;
  localparam logic [1:0] c_ror = 2'b11;

  function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] x,
                                                   input logic [1:0]       m,
                                                   input int               n);
    logic [WIDTH-1:0] r;
    case (m)
      c_sll:   r = x << n;
      c_srl:   r = x >> n;
      c_sra:   r = $unsigned($signed(x) >>> n);
      c_ror:   r = (x >> n) | (x << (WIDTH - n));
      default: r = x;
    endcase
    return r;
  endfunction

  logic [STAGES-1:0]  valid_q;
  logic [STAGES-1:0]  adv;
  logic [STAGES-1:0]  src_valid;
  logic [WIDTH-1:0]   data_q   [STAGES];
  logic [WIDTH-1:0]   data_d   [STAGES];
  logic [WIDTH-1:0]   src_data [STAGES];
  logic [1:0]         mode_q   [STAGES];
  logic [1:0]         src_mode [STAGES];
  logic [SHAMT_W-1:0] amt_q    [STAGES];
  logic [SHAMT_W-1:0] src_amt  [STAGES];
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_amt;

`ifdef PIPE_SHIFTER_SAT_EN
  logic              in_ovf;
  logic [STAGES-1:0] ovf_q;
  logic [STAGES-1:0] src_ovf;

  assign in_ovf = |shiftnum[31:SHAMT_W];

  // Saturation is resolved up front: the operand is replaced and the amount zeroed.
  always_comb begin
    in_data = datain;
    in_amt  = shiftnum[SHAMT_W-1:0];
    if (in_ovf && (mode != c_ror)) begin
      in_data = (mode == c_sra) ? {WIDTH{datain[WIDTH-1]}} : '0;
      in_amt  = '0;
    end
  end

  always_comb begin
    src_ovf    = '0;
    src_ovf[0] = in_ovf;
    for (int s = 1; s < STAGES; s++) src_ovf[s] = ovf_q[s-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= '0;
    end else begin
      for (int s = 0; s < STAGES; s++)
        if (adv[s] && src_valid[s]) ovf_q[s] <= src_ovf[s];
    end
  end

  assign shamt_ovf = ovf_q[STAGES-1];
`else
  assign in_data   = datain;
  assign in_amt    = shiftnum[SHAMT_W-1:0];
  assign shamt_ovf = 1'b0;
`endif

  always_comb begin
    src_valid    = '0;
    src_valid[0] = in_valid;
    src_data[0]  = in_data;
    src_mode[0]  = mode;
    src_amt[0]   = in_amt;
    for (int s = 1; s < STAGES; s++) begin
      src_valid[s] = valid_q[s-1];
      src_data[s]  = data_q[s-1];
      src_mode[s]  = mode_q[s-1];
      src_amt[s]   = amt_q[s-1];
    end
  end

  // Ready chain: a stage moves if it is empty or everything ahead of it moves.
  always_comb begin
    logic chain;
    adv   = '0;
    chain = out_ready;
    for (int s = STAGES - 1; s >= 0; s--) begin
      chain  = !valid_q[s] || chain;
      adv[s] = chain;
    end
  end

  // Level k lives in stage floor(k*STAGES/SHAMT_W).
  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      data_d[s] = src_data[s];
      for (int k = 0; k < SHAMT_W; k++) begin
        if (((k * STAGES) / SHAMT_W == s) && src_amt[s][k])
          data_d[s] = shift_level(data_d[s], src_mode[s], 1 << k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int s = 0; s < STAGES; s++) begin
        data_q[s] <= '0;
        mode_q[s] <= '0;
        amt_q[s]  <= '0;
      end
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (adv[s]) begin
          valid_q[s] <= src_valid[s];
          if (src_valid[s]) begin
            data_q[s] <= data_d[s];
            mode_q[s] <= src_mode[s];
            amt_q[s]  <= src_amt[s];
          end
        end
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = valid_q[STAGES-1];
  assign dataout   = data_q[STAGES-1];

  logic unused_tail;
  assign unused_tail = ^{shiftnum[31:SHAMT_W], mode_q[STAGES-1], amt_q[STAGES-1]};

endmodule
`default_nettype wire

// File: tb/tb_pipe_shifter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_shifter
// Purpose  : Directed and randomized checks of pipe_shifter against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_shifter;

  localparam int WIDTH  = 32;
  localparam int STAGES = 2;
  localparam int SW     = $clog2(WIDTH);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] datain;
  logic [31:0]      shiftnum;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] dataout;
  logic             shamt_ovf;

  pipe_shifter #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .datain(datain), .shiftnum(shiftnum), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .dataout(dataout), .shamt_ovf(shamt_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             ovf;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   acc_total   = 0;
  logic acc_flag    = 1'b0;
  logic             prev_hold = 1'b0;
  logic [WIDTH-1:0] prev_data;
  logic             prev_ovf;

  function automatic exp_t model(input logic [WIDTH-1:0] d, input logic [31:0] sn,
                                 input logic [1:0] m);
    exp_t e;
    int   a;
    a     = int'(sn[SW-1:0]);
    e.ovf = 1'b0;
    case (m)
      2'd0:    e.d = d << a;
      2'd1:    e.d = d >> a;
      2'd2:    e.d = $unsigned($signed(d) >>> a);
      default: e.d = (a == 0) ? d : ((d >> a) | (d << (WIDTH - a)));
    endcase
`ifdef PIPE_SHIFTER_SAT_EN
    e.ovf = (sn >= 32'(WIDTH));
    if (e.ovf) begin
      if (m == 2'd0 || m == 2'd1) e.d = '0;
      else if (m == 2'd2)         e.d = {WIDTH{d[WIDTH-1]}};
    end
`endif
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the ordered queue of accepted operations.
  always @(negedge clk) begin
    exp_t e;
    acc_flag = 1'b0;
    if (rst) begin
      q.delete();
      prev_hold = 1'b0;
    end else begin
      check("in_ready", 64'(in_ready), 64'((q.size() < STAGES) || out_ready));
      if (q.size() == 0) check("idle_out_valid", 64'(out_valid), 64'd0);
      if (prev_hold) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", 64'(dataout), 64'(prev_data));
        check("hold_ovf", 64'(shamt_ovf), 64'(prev_ovf));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("spurious_result", 64'(out_valid), 64'd0);
        end else begin
          e = q.pop_front();
          check("result_data", 64'(dataout), 64'(e.d));
          check("result_ovf", 64'(shamt_ovf), 64'(e.ovf));
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(datain, shiftnum, mode));
        acc_total++;
        acc_flag = 1'b1;
      end
      prev_hold = out_valid && !out_ready;
      prev_data = dataout;
      prev_ovf  = shamt_ovf;
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [WIDTH-1:0] d, input logic [31:0] sn,
                      input logic [1:0] m, output int waits);
    in_valid = 1'b1;
    datain   = d;
    shiftnum = sn;
    mode     = m;
    waits    = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (!in_ready && waits < 100);
    if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [WIDTH-1:0] d, input logic o,
                            input int want_k);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(out_valid && out_ready) && k < 100);
    check({name, "_seen"}, 64'(out_valid && out_ready), 64'd1);
    check({name, "_data"}, 64'(dataout), 64'(d));
    check({name, "_ovf"}, 64'(shamt_ovf), 64'(o));
    if (want_k > 0) check({name, "_cycles"}, 64'(k), 64'(want_k));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    int acc0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    datain = '0; shiftnum = '0; mode = 2'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_dataout", 64'(dataout), 64'd0);
    check("rst_ovf", 64'(shamt_ovf), 64'd0);
    @(posedge clk);
    #1;

    // Latency and basic modes
    out_ready = 1'b1;
    send(32'h0000_0001, 32'd31, 2'd0, w); expect_out("sll31", 32'h8000_0000, 1'b0, STAGES);
    send(32'h8000_0000, 32'd4, 2'd2, w);  expect_out("sra4", 32'hF800_0000, 1'b0, STAGES);
    send(32'h8000_0000, 32'd4, 2'd1, w);  expect_out("srl4", 32'h0800_0000, 1'b0, STAGES);
    send(32'h1234_5678, 32'd8, 2'd3, w);  expect_out("ror8", 32'h7812_3456, 1'b0, STAGES);
    send(32'hA5A5_0F0F, 32'd0, 2'd3, w);  expect_out("ror0", 32'hA5A5_0F0F, 1'b0, STAGES);

    // Backpressure with five back-to-back ops
    out_ready = 1'b0;
    acc0 = acc_total;
    fork
      begin
        for (int i = 0; i < 5; i++) send(32'h1, 32'(i), 2'd0, w);
      end
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_data", 64'(dataout), 64'h1);
        @(posedge clk);
        #1;
        check("stall_accepts", 64'(acc_total - acc0), 64'd2);
        out_ready = 1'b1;
        expect_out("bp0", 32'h01, 1'b0, 1);
        expect_out("bp1", 32'h02, 1'b0, 1);
        expect_out("bp2", 32'h04, 1'b0, 1);
        expect_out("bp3", 32'h08, 1'b0, 1);
        expect_out("bp4", 32'h10, 1'b0, 1);
      end
    join

    // Bubble collapse
    out_ready = 1'b0;
    send(32'h0000_00F0, 32'd4, 2'd1, w);
    repeat (3) @(posedge clk);
    #1;
    send(32'h0000_0001, 32'd1, 2'd3, w);
    check("bubble_b_accept_wait", 64'(w), 64'd1);
    out_ready = 1'b1;
    expect_out("bubble_a", 32'h0000_000F, 1'b0, 1);
    expect_out("bubble_b", 32'h8000_0000, 1'b0, 1);

    // Amount beyond range
`ifdef PIPE_SHIFTER_SAT_EN
    send(32'h1, 32'd33, 2'd0, w);          expect_out("sll33", 32'h0, 1'b1, STAGES);
    send(32'h8000_0000, 32'd40, 2'd2, w);  expect_out("sra40", 32'hFFFF_FFFF, 1'b1, STAGES);
    send(32'h0000_00FF, 32'd36, 2'd3, w);  expect_out("ror36", 32'hF000_000F, 1'b1, STAGES);
`else
    send(32'h1, 32'd33, 2'd0, w);          expect_out("sll33", 32'h2, 1'b0, STAGES);
    send(32'h8000_0000, 32'd40, 2'd2, w);  expect_out("sra40", 32'hFF80_0000, 1'b0, STAGES);
    send(32'h0000_00FF, 32'd36, 2'd3, w);  expect_out("ror36", 32'hF000_000F, 1'b0, STAGES);
`endif

    // Reset with two ops in flight
    out_ready = 1'b0;
    send(32'hDEAD_BEEF, 32'd3, 2'd1, w);
    send(32'h0F0F_0F0F, 32'd5, 2'd0, w);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_dataout", 64'(dataout), 64'd0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    send(32'h0000_0003, 32'd2, 2'd0, w);   expect_out("post_rst", 32'h0000_000C, 1'b0, STAGES);

    // Randomized traffic with random backpressure
    in_valid = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!in_valid || acc_flag) begin
        in_valid = ($urandom % 3) != 0;
        datain   = WIDTH'($urandom);
        shiftnum = ($urandom % 4 == 0) ? $urandom : ($urandom % WIDTH);
        mode     = 2'($urandom);
      end
      out_ready = ($urandom % 3) != 0;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("drain_empty", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_shifter.md
Name: pipe_shifter

Overview:
- Parametrised, pipelined barrel shifter for the EX stage; successor to the 32-bit left-only combinational shifter.
- Supports SLL, SRL, SRA and ROR on a WIDTH-bit operand.
- log2(WIDTH) mux levels are split across STAGES register boundaries.
- Elastic valid/ready handshake on input and output lets the pipeline absorb stalls without losing operations.

Parameters:
- WIDTH, 32, operand width; must be a power of two, 8..64.
- STAGES, 2, number of register stages, 1..log2(WIDTH); equals latency in cycles.
- SHAMT_W, log2(WIDTH), derived, not overridable; effective shift-amount width.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operation present on input
- in_ready  output  1  block can accept operation this cycle
- datain  input  WIDTH  operand
- shiftnum  input  32  shift amount; low SHAMT_W bits used, upper bits see optional feature
- mode  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- dataout  output  WIDTH  shifted result
- shamt_ovf  output  1  shift amount was >= WIDTH (optional feature)

Behaviour:
- Reset: rst sampled on clk.
  - All stage valid bits are cleared; data, mode and amount registers go to 0.
  - out_valid=0, dataout=0, shamt_ovf=0.
  - in_ready=1 in the first cycle after reset.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Level mapping:
  - Mux level k (shift by 2^k, k=0..SHAMT_W-1) is placed in stage floor(k*STAGES/SHAMT_W).
  - Each stage registers its partial result, mode and the remaining amount bits.
- Latency: exactly STAGES cycles from input transfer to out_valid when never stalled. Throughput is 1 op/cycle.
- Elastic stages:
  - Stage i loads when its valid is clear or stage i+1 accepts in the same cycle.
  - The last stage advances when out_ready or !out_valid.
  - in_ready = !v[0] || stage 0 advancing. This is a combinational ready chain; no skid buffer.
  - Bubbles collapse: an empty stage is refilled even while downstream is stalled.
- Ordering: results leave in acceptance order; no reordering, duplication or drop.
- Output hold: while out_valid && !out_ready, dataout and shamt_ovf stay stable.
- Mode behaviour:
  - SLL zero-fills the LSBs.
  - SRL zero-fills the MSBs.
  - SRA fills the MSBs with datain[WIDTH-1], captured at acceptance.
  - ROR wraps bits around.
  - Amount 0 passes datain unchanged in all modes.
- Mode is captured at acceptance and carried with the data; it never changes mid-flight.
- Simultaneous events:
  - An input accept and an output retire in the same cycle with a full pipeline is legal; occupancy is unchanged.
  - rst wins over any transfer in the same cycle.
- Reset mid-operation: all in-flight operations are discarded. No result is produced for them and out_valid is 0 the cycle after reset.
- Amount beyond range: without the optional feature, the effective amount is shiftnum mod WIDTH.

Optional Feature:
- Macro: PIPE_SHIFTER_SAT_EN
- Defined:
  - shamt_ovf = |shiftnum[31:SHAMT_W], captured at acceptance.
  - When shamt_ovf=1: SLL and SRL produce 0; SRA produces all sign bits; ROR still uses amount mod WIDTH.
  - shamt_ovf travels with the result and is valid whenever out_valid=1.
- Undefined:
  - shamt_ovf is tied to 0.
  - The upper shiftnum bits are ignored; all modes use amount mod WIDTH.
  - No extra flop is present.

Test Plan:
1. WIDTH=32, STAGES=2; SLL datain=0x00000001, shiftnum=31, out_ready=1 -> dataout=0x80000000 with out_valid exactly 2 cycles after accept.
2. datain=0x80000000, shiftnum=4: SRA -> 0xF8000000; SRL -> 0x08000000; ROR of 0x12345678 by 8 -> 0x78123456.
3. Backpressure: 5 back-to-back ops, out_ready=0 for 4 cycles.
   - in_ready drops after 2 accepts.
   - Resuming out_ready=1 yields all 5 results in order, 1/cycle.
   - dataout is stable while stalled.
4. Bubble collapse: send op A, hold out_ready=0, send op B 3 cycles later -> B is accepted; both are held. Release -> A then B on consecutive cycles.
5. shiftnum=33, datain=0x1 SLL:
   - Without the macro -> 0x00000002, shamt_ovf=0.
   - With the macro -> 0x00000000, shamt_ovf=1.
   - With the macro, SRA 0x80000000 by 40 -> 0xFFFFFFFF.
6. Assert rst for 1 cycle with 2 ops in flight -> next cycle out_valid=0, in_ready=1, dataout=0; neither op is ever emitted; a new op after reset completes normally.
